// File: rtl/layer1_maxpool.sv
// Layer-1 2x2 stride-2 max pooling: streams four reads per output pixel from the
// Layer-0 maps and writes the signed maximum into the matching Layer-1 map.
module layer1_maxpool #(
  parameter int IMG_W = 64,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] cdata_rd,
  output logic          crd1,
  output logic [AW-1:0] caddr_rd1,
  output logic          cwr1,
  output logic [AW-1:0] caddr_wr1,
  output logic [DW-1:0] cdata_wr1,
  output logic [2:0]    csel1,
  output logic          Finish1
);

  localparam int HW = IMG_W / 2;
  localparam int RW = $clog2(HW);

  typedef enum logic [2:0] {IDLE, RD, LAST, WR, FIN} state_t;

  state_t          state, state_nxt;
  logic            start_d;
  logic            k;
  logic [RW-1:0]   r, c;
  logic [1:0]      w;
  logic [DW-1:0]   max_q;
  logic            launch, c_wrap, r_wrap;
  logic [2*RW+1:0] rd_idx;
  logic [2*RW-1:0] wr_idx;

  assign launch = start & ~start_d;
  assign c_wrap = (c == RW'(HW - 1));
  assign r_wrap = (r == RW'(HW - 1));
  assign rd_idx = {r, w[1], c, w[0]};
  assign wr_idx = {r, c};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = RD;
      RD:   if (w == 2'd3) state_nxt = LAST;
      LAST: state_nxt = WR;
      WR:   state_nxt = (k && c_wrap && r_wrap) ? FIN : RD;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters wrap naturally, so a finished run leaves k, r, c, w back at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_d <= 1'b0;
      k       <= 1'b0;
      r       <= '0;
      c       <= '0;
      w       <= '0;
    end else begin
      start_d <= start;
      case (state)
        RD: w <= w + 2'd1;
        WR: begin
          c <= c + 1'b1;
          if (c_wrap) begin
            r <= r + 1'b1;
            if (r_wrap) k <= ~k;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data lags its address by one cycle: the w=0 datum lands in RD(w=1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else if ((state == RD && w != 2'd0) || state == LAST) begin
      if (state == RD && w == 2'd1)
        max_q <= cdata_rd;
      else if ($signed(cdata_rd) > $signed(max_q))
        max_q <= cdata_rd;
    end
  end

  always_comb begin
    crd1      = 1'b0;
    caddr_rd1 = '0;
    cwr1      = 1'b0;
    caddr_wr1 = '0;
    cdata_wr1 = '0;
    csel1     = 3'b000;
    Finish1   = 1'b0;
    case (state)
      RD: begin
        crd1      = 1'b1;
        csel1     = k ? 3'b010 : 3'b001;
        caddr_rd1 = AW'(rd_idx);
      end
      LAST: csel1 = k ? 3'b010 : 3'b001;
      WR: begin
        cwr1      = 1'b1;
        csel1     = k ? 3'b100 : 3'b011;
        caddr_wr1 = AW'(wr_idx);
        cdata_wr1 = max_q;
      end
      FIN: Finish1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer1_maxpool.sv
// Bench for layer1_maxpool: behavioural memories, bus monitor and a window-max
// reference model over randomized and structured Layer-0 images.
module tb_layer1_maxpool;

  localparam int IMG_W   = 64;
  localparam int DW      = 20;
  localparam int AW      = 12;
  localparam int HW      = IMG_W / 2;
  localparam int NPIX    = HW * HW;
  localparam int NIN     = IMG_W * IMG_W;
  localparam int RUN_CYC = 2 * NPIX * 6 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] cdata_rd;
  logic          crd1, cwr1, Finish1;
  logic [AW-1:0] caddr_rd1, caddr_wr1;
  logic [DW-1:0] cdata_wr1;
  logic [2:0]    csel1;
  logic [2*AW+DW+5:0] out_bus;

  layer1_maxpool #(.IMG_W(IMG_W), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .cdata_rd(cdata_rd),
    .crd1(crd1), .caddr_rd1(caddr_rd1), .cwr1(cwr1), .caddr_wr1(caddr_wr1),
    .cdata_wr1(cdata_wr1), .csel1(csel1), .Finish1(Finish1)
  );

  assign out_bus = {crd1, caddr_rd1, cwr1, caddr_wr1, cdata_wr1, csel1, Finish1};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] l0 [2][NIN];
  logic [DW-1:0] l1 [2][NPIX];
  logic [DW-1:0] l1_save [2][NPIX];
  logic [DW-1:0] cls_exp [2][NPIX];
  bit            cls_known [2][NPIX];

  int cycle = 0, reads = 0, writes = 0, viol = 0, fin_count = 0;
  int fin_cycle = -1, first_rd_cycle = -1, launch_ref = 0;
  int mon_k, mon_p, mon_w, mon_exp;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr_s = '0;
  logic [2:0]    rd_sel_s = '0;
  logic          prev_crd = 1'b0;
  logic [2:0]    prev_sel = '0;

  always @(posedge clk) cycle++;

  // Layer-0 memory: answers the read seen in cycle N during cycle N+1, noise otherwise.
  always @(posedge clk) begin
    if (rd_pend) cdata_rd <= l0[(rd_sel_s == 3'b010) ? 1 : 0][rd_addr_s];
    else         cdata_rd <= DW'($urandom);
  end

  // Bus monitor: expected read/write order is derived from the count of transfers so far.
  always @(negedge clk) begin
    if (crd1 && cwr1) viol++;
    if (crd1) begin
      if (reads == 0) first_rd_cycle = cycle;
      mon_k   = reads / (NPIX * 4);
      mon_p   = (reads % (NPIX * 4)) / 4;
      mon_w   = reads % 4;
      mon_exp = (2 * (mon_p / HW) + mon_w / 2) * IMG_W + 2 * (mon_p % HW) + mon_w % 2;
      if (csel1 !== (mon_k != 0 ? 3'b010 : 3'b001) || caddr_rd1 !== AW'(mon_exp)) viol++;
      reads++;
    end else if (caddr_rd1 !== '0) viol++;
    if (cwr1) begin
      mon_k = writes / NPIX;
      if (mon_k > 1 || csel1 !== (mon_k != 0 ? 3'b100 : 3'b011) ||
          caddr_wr1 !== AW'(writes % NPIX)) viol++;
      else l1[mon_k][writes % NPIX] = cdata_wr1;
      writes++;
    end else if (caddr_wr1 !== '0 || cdata_wr1 !== '0) viol++;
    if (!crd1 && !cwr1 && csel1 !== ((prev_crd && !reset) ? prev_sel : 3'b000)) viol++;
    if (Finish1) begin
      fin_count++;
      fin_cycle = cycle;
    end
    prev_crd  = crd1;
    prev_sel  = csel1;
    rd_pend   = crd1;
    rd_addr_s = caddr_rd1;
    rd_sel_s  = csel1;
  end

  function automatic int addr_of(int r, int c, int w);
    return (2 * r + w / 2) * IMG_W + 2 * c + w % 2;
  endfunction

  function automatic logic [DW-1:0] ref_max(int k, int r, int c);
    logic signed [DW-1:0] best, v;
    best = l0[k][addr_of(r, c, 0)];
    for (int w = 1; w < 4; w++) begin
      v = l0[k][addr_of(r, c, w)];
      if (v > best) best = v;
    end
    return best;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < NIN; a++) l0[k][a] = DW'($urandom);
  endtask

  task automatic launch_run(input bit hold);
    @(posedge clk); #1;
    reads = 0; writes = 0; viol = 0; fin_count = 0;
    fin_cycle = -1; first_rd_cycle = -1;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < NPIX; a++) l1[k][a] = 'x;
    launch_ref = cycle;
    start = 1'b1;
    if (!hold) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (fin_count > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    #12;
    total++;
    if (out_bus !== '0) begin bad++; $display("[TB] FAIL reset_outputs: got %h want 0", out_bus); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (out_bus !== '0) begin bad++; $display("[TB] FAIL idle_outputs: got %h want 0", out_bus); end
    total++;
    if (reads !== 0 || writes !== 0) begin
      bad++; $display("[TB] FAIL idle_traffic: got reads=%0d writes=%0d want 0/0", reads, writes);
    end
  endtask

  task automatic test_ramp();
    bit ok;
    int errs0, errs1, ferr;
    for (int a = 0; a < NIN; a++) begin
      l0[0][a] = DW'(a);
      l0[1][a] = DW'(4095 - a);
    end
    launch_run(1'b0);
    wait_finish(RUN_CYC + 100, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL ramp_timeout: got no Finish1 want Finish1"); end
    total++;
    if (fin_count !== 1) begin bad++; $display("[TB] FAIL ramp_finish_count: got %0d want 1", fin_count); end
    total++;
    if (fin_cycle - launch_ref !== RUN_CYC) begin
      bad++; $display("[TB] FAIL ramp_finish_cycle: got %0d want %0d", fin_cycle - launch_ref, RUN_CYC);
    end
    total++;
    if (first_rd_cycle - launch_ref !== 1) begin
      bad++; $display("[TB] FAIL ramp_first_read: got %0d want 1", first_rd_cycle - launch_ref);
    end
    total++;
    if (reads !== 2 * NPIX * 4 || writes !== 2 * NPIX) begin
      bad++; $display("[TB] FAIL ramp_counts: got reads=%0d writes=%0d want %0d/%0d", reads, writes, 2 * NPIX * 4, 2 * NPIX);
    end
    total++;
    if (viol !== 0) begin bad++; $display("[TB] FAIL ramp_protocol: got %0d violations want 0", viol); end
    errs0 = 0; errs1 = 0; ferr = 0;
    for (int r = 0; r < HW; r++)
      for (int c = 0; c < HW; c++) begin
        if (l1[0][r * HW + c] !== ref_max(0, r, c)) errs0++;
        if (l1[1][r * HW + c] !== ref_max(1, r, c)) errs1++;
        if (l1[0][r * HW + c] !== DW'((2 * r + 1) * IMG_W + 2 * c + 1) ||
            l1[1][r * HW + c] !== DW'(4095 - (2 * r * IMG_W + 2 * c))) ferr++;
      end
    total++;
    if (errs0 !== 0 || errs1 !== 0) begin
      bad++; $display("[TB] FAIL ramp_model: got %0d/%0d bad pixels want 0/0", errs0, errs1);
    end
    total++;
    if (ferr !== 0) begin bad++; $display("[TB] FAIL ramp_formula: got %0d bad pixels want 0", ferr); end
  endtask

  task automatic test_window_signed();
    bit ok;
    int p, rr, cc, cerr, merr;
    logic [DW-1:0] v;
    fill_random();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NPIX; i++) begin
        rr = i / HW; cc = i % HW; p = (i + k) % 8;
        cls_known[k][i] = 1'b1;
        case (p)
          0, 1, 2, 3: begin
            for (int w = 0; w < 4; w++) begin
              v = DW'($urandom);
              if (v == 20'h7FFFF) v = '0;
              l0[k][addr_of(rr, cc, w)] = v;
            end
            l0[k][addr_of(rr, cc, p)] = 20'h7FFFF;
            cls_exp[k][i] = 20'h7FFFF;
          end
          4: begin
            for (int w = 0; w < 4; w++) l0[k][addr_of(rr, cc, w)] = '0;
            cls_exp[k][i] = '0;
          end
          5: begin
            l0[k][addr_of(rr, cc, 0)] = 20'h80000;
            l0[k][addr_of(rr, cc, 1)] = 20'h00001;
            l0[k][addr_of(rr, cc, 2)] = '0;
            l0[k][addr_of(rr, cc, 3)] = '0;
            cls_exp[k][i] = 20'h00001;
          end
          6: begin
            l0[k][addr_of(rr, cc, 0)] = '0;
            l0[k][addr_of(rr, cc, 1)] = '0;
            l0[k][addr_of(rr, cc, 2)] = 20'h00001;
            l0[k][addr_of(rr, cc, 3)] = 20'h80000;
            cls_exp[k][i] = 20'h00001;
          end
          default: begin
            cls_known[k][i] = 1'b0;
            cls_exp[k][i] = '0;
          end
        endcase
      end
    launch_run(1'b0);
    wait_finish(RUN_CYC + 100, ok);
    total++;
    if (!ok || fin_count !== 1) begin
      bad++; $display("[TB] FAIL window_finish: got ok=%0d count=%0d want 1/1", ok, fin_count);
    end
    total++;
    if (viol !== 0 || writes !== 2 * NPIX) begin
      bad++; $display("[TB] FAIL window_protocol: got viol=%0d writes=%0d want 0/%0d", viol, writes, 2 * NPIX);
    end
    cerr = 0; merr = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NPIX; i++) begin
        if (cls_known[k][i] && l1[k][i] !== cls_exp[k][i]) begin
          if (cerr == 0) $display("[TB] FAIL window_first: k=%0d pix=%0d got %h want %h", k, i, l1[k][i], cls_exp[k][i]);
          cerr++;
        end
        if (l1[k][i] !== ref_max(k, i / HW, i % HW)) merr++;
      end
    total++;
    if (cerr !== 0) begin bad++; $display("[TB] FAIL window_planted: got %0d bad pixels want 0", cerr); end
    total++;
    if (merr !== 0) begin bad++; $display("[TB] FAIL window_model: got %0d bad pixels want 0", merr); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int merr, serr;
    fill_random();
    launch_run(1'b1);
    while (cycle - launch_ref < 6000) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    wait_finish(RUN_CYC + 100, ok);
    repeat (100) @(posedge clk);
    #1;
    total++;
    if (!ok || fin_count !== 1) begin
      bad++; $display("[TB] FAIL held_finish: got ok=%0d count=%0d want 1/1", ok, fin_count);
    end
    total++;
    if (reads !== 2 * NPIX * 4 || writes !== 2 * NPIX || viol !== 0) begin
      bad++; $display("[TB] FAIL held_counts: got reads=%0d writes=%0d viol=%0d want %0d/%0d/0", reads, writes, viol, 2 * NPIX * 4, 2 * NPIX);
    end
    merr = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NPIX; i++) begin
        if (l1[k][i] !== ref_max(k, i / HW, i % HW)) merr++;
        l1_save[k][i] = l1[k][i];
      end
    total++;
    if (merr !== 0) begin bad++; $display("[TB] FAIL held_model: got %0d bad pixels want 0", merr); end
    start = 1'b0;
    repeat (5) @(posedge clk);
    launch_run(1'b0);
    wait_finish(RUN_CYC + 100, ok);
    total++;
    if (!ok || fin_count !== 1 || fin_cycle - launch_ref !== RUN_CYC) begin
      bad++; $display("[TB] FAIL rerun_finish: got ok=%0d count=%0d cycle=%0d want 1/1/%0d", ok, fin_count, fin_cycle - launch_ref, RUN_CYC);
    end
    serr = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NPIX; i++)
        if (l1[k][i] !== l1_save[k][i] || l1[k][i] !== ref_max(k, i / HW, i % HW)) serr++;
    total++;
    if (serr !== 0 || viol !== 0) begin
      bad++; $display("[TB] FAIL rerun_data: got %0d bad pixels viol=%0d want 0/0", serr, viol);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int merr, reads_hold;
    fill_random();
    launch_run(1'b0);
    while (cycle - launch_ref < 5000) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_bus !== '0) begin bad++; $display("[TB] FAIL midreset_outputs: got %h want 0", out_bus); end
    repeat (10) @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    reads_hold = reads;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (fin_count !== 0 || reads !== reads_hold) begin
      bad++; $display("[TB] FAIL midreset_quiet: got fin=%0d new_reads=%0d want 0/0", fin_count, reads - reads_hold);
    end
    launch_run(1'b0);
    wait_finish(RUN_CYC + 100, ok);
    total++;
    if (!ok || fin_count !== 1 || fin_cycle - launch_ref !== RUN_CYC) begin
      bad++; $display("[TB] FAIL recover_finish: got ok=%0d count=%0d cycle=%0d want 1/1/%0d", ok, fin_count, fin_cycle - launch_ref, RUN_CYC);
    end
    merr = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NPIX; i++)
        if (l1[k][i] !== ref_max(k, i / HW, i % HW)) merr++;
    total++;
    if (merr !== 0 || viol !== 0 || reads !== 2 * NPIX * 4) begin
      bad++; $display("[TB] FAIL recover_data: got bad=%0d viol=%0d reads=%0d want 0/0/%0d", merr, viol, reads, 2 * NPIX * 4);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_window_signed();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
